// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO registers.
// Define MULT_DIV_SIGNED_OPS_EN to add signed MULT/DIV (op 10/11); otherwise op[1] is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_divz;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_accept;
  logic             w_commit;

`ifdef MULT_DIV_SIGNED_OPS_EN
  logic               w_signed;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic [WIDTH-1:0]   r_a_raw;
  logic [2*WIDTH-1:0] w_neg_prod;

  assign w_signed   = op[1];
  assign w_a_mag    = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag    = (w_signed && b[WIDTH-1]) ? -b : b;
  assign w_neg_prod = -{r_acc_hi, r_acc_lo};
`else
  logic w_unused_op1;

  assign w_unused_op1 = op[1];
  assign w_a_mag      = a;
  assign w_b_mag      = b;
`endif

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_commit = (r_state == S_DONE) && !flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN: begin
        if (flush)                    w_state_next = S_IDLE;
        else if (r_cnt == CNT_W'(1))  w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result is shown combinationally in DONE so a same-cycle flush can still suppress it.
  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = w_commit;
    div_by_zero = w_commit && r_divz;
    hi          = w_commit ? w_res_hi : r_hi;
    lo          = w_commit ? w_res_lo : r_lo;
  end

  // One iteration: acc_hi is the partial product / remainder, acc_lo the multiplier / quotient.
  always_comb begin
    w_sum     = '0;
    w_shift   = '0;
    w_diff    = '0;
    w_iter_hi = r_acc_hi;
    w_iter_lo = r_acc_lo;
    if (r_is_div) begin
      w_shift   = {r_acc_hi, r_acc_lo[WIDTH-1]};
      w_diff    = w_shift - {1'b0, r_opnd};
      w_iter_lo = {r_acc_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      w_iter_hi = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end else begin
      w_sum     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
      w_iter_hi = w_sum[WIDTH:1];
      w_iter_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_res_hi = r_acc_hi;
    w_res_lo = r_acc_lo;
`ifdef MULT_DIV_SIGNED_OPS_EN
    if (!r_is_div && r_neg_lo) begin
      {w_res_hi, w_res_lo} = w_neg_prod;
    end else if (r_is_div) begin
      if (r_neg_lo) w_res_lo = -r_acc_lo;
      if (r_neg_hi) w_res_hi = -r_acc_hi;
    end
`endif
    if (r_divz) begin
      w_res_lo = '1;
`ifdef MULT_DIV_SIGNED_OPS_EN
      w_res_hi = r_a_raw;
`else
      // With a zero divisor every trial subtract succeeds, so the remainder ends up equal to a.
      w_res_hi = r_acc_hi;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_divz   <= 1'b0;
      r_opnd   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MULT_DIV_SIGNED_OPS_EN
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_a_raw  <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_cnt    <= CNT_W'(WIDTH);
        r_is_div <= op[0];
        r_divz   <= op[0] && (b == '0);
        r_opnd   <= w_b_mag;
        r_acc_hi <= '0;
        r_acc_lo <= w_a_mag;
`ifdef MULT_DIV_SIGNED_OPS_EN
        r_neg_lo <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_hi <= w_signed && a[WIDTH-1];
        r_a_raw  <= a;
`endif
      end else if (r_state == S_RUN) begin
        if (flush) begin
          r_cnt <= '0;
        end else begin
          r_cnt    <= r_cnt - CNT_W'(1);
          r_acc_hi <= w_iter_hi;
          r_acc_lo <= w_iter_lo;
        end
      end
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

endmodule
